eco32f_divider: RTL and testbench

Parametrised iterative integer divider, successor to the ALU's built-in serial divider. Produces quotient and remainder for signed or unsigned operands. Retires STEP quotient bits per cycle and uses valid/ready handshakes on both sides, so the ALU and pipeline control can issue, back-pressure and flush it independently. Sits beside the ALU in EX; the pipeline stalls on !in_ready / !out_valid.

---
 rtl/eco32f_divider_if.sv | 29 ++
 rtl/eco32f_divider.sv | 141 ++++++++++++++
 tb/tb_eco32f_divider.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eco32f_divider_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// Pipeline side drives requests and consumes results (master); divider is slave.
// Handshakes are valid/ready on both the request and the result side.
interface eco32f_divider_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_dbz;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dbz
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dbz
  );

endinterface

// File: rtl/eco32f_divider.sv
// Iterative restoring divider (signed/unsigned), STEP quotient bits per cycle.
// Latency: WIDTH/STEP cycles from accept to out_valid; divide-by-zero is ready right after accept.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; kill flushes any state.
module eco32f_divider #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  output logic             busy,
  eco32f_divider_if.slave  bus
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = $clog2(NSTEPS + 1);

  generate
    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_param
      $error("eco32f_divider: WIDTH must be >= 2 and a multiple of STEP");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  // Dividend magnitude shifts out of the MSB while quotient bits shift into the LSB.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             div_zero;
  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;

  logic [WIDTH-1:0] step_dvd;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign bus.in_ready  = (state == IDLE) & ~kill;
  assign bus.out_valid = (state == DONE);
  assign busy          = (state != IDLE);

  assign accept   = bus.in_valid & bus.in_ready;
  assign div_zero = (bus.in_divisor == '0);
  assign x_neg    = bus.in_signed & bus.in_dividend[WIDTH-1];
  assign y_neg    = bus.in_signed & bus.in_divisor[WIDTH-1];
  assign x_mag    = x_neg ? -bus.in_dividend : bus.in_dividend;
  assign y_mag    = y_neg ? -bus.in_divisor  : bus.in_divisor;

  // STEP chained restoring iterations, MSB first. The partial remainder is always
  // below the divisor, so a carry out of the shift implies a non-negative trial.
  always_comb begin
    step_dvd = dvd;
    step_rem = rem;
    shifted  = '0;
    diff     = '0;
    for (int i = 0; i < STEP; i++) begin
      shifted  = {step_rem, step_dvd[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      step_dvd = {step_dvd[WIDTH-2:0], ~diff[WIDTH]};
      step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  // Sign correction for truncating division: remainder follows the dividend.
  assign q_fin = q_neg ? -step_dvd : step_dvd;
  assign r_fin = r_neg ? -step_rem : step_rem;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; kill wins over every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Operand capture, iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      bus.out_quot <= '0;
      bus.out_rem  <= '0;
      bus.out_dbz  <= 1'b0;
    end else if (accept) begin
      cnt   <= CW'(NSTEPS);
      dvd   <= x_mag;
      dvs   <= y_mag;
      rem   <= '0;
      q_neg <= x_neg ^ y_neg;
      r_neg <= x_neg;
      if (div_zero) begin
        bus.out_quot <= '1;
        bus.out_rem  <= bus.in_dividend;
        bus.out_dbz  <= 1'b1;
      end
    end else if (state == CALC && !kill) begin
      cnt <= cnt - CW'(1);
      dvd <= step_dvd;
      rem <= step_rem;
      if (cnt == CW'(1)) begin
        bus.out_quot <= q_fin;
        bus.out_rem  <= r_fin;
        bus.out_dbz  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eco32f_divider.sv
// Directed bench for eco32f_divider: STEP=1 and STEP=4 instances.
// Stimulus pushes hand-computed results into per-DUT queues; monitors pop on handshake.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_eco32f_divider;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic kill  = 1'b0;
  logic kill4 = 1'b0;
  logic busy;
  logic busy4;

  eco32f_divider_if #(.WIDTH(32)) bus1 ();
  eco32f_divider_if #(.WIDTH(32)) bus4 ();

  eco32f_divider #(.WIDTH(32), .STEP(1)) u_dut (
    .clk(clk), .rst(rst), .kill(kill), .busy(busy), .bus(bus1)
  );

  eco32f_divider #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .kill(kill4), .busy(busy4), .bus(bus4)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb1[$];
  exp_t sb4[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor for the STEP=1 instance; latency = edges from accept to first out_valid.
  logic v1_prev = 1'b0;
  int   first1  = 0;
  always @(negedge clk) begin
    if (!rst) begin
      v1_prev = 1'b0;
    end else begin
      if (bus1.out_valid && !v1_prev) first1 = cyc;
      v1_prev = bus1.out_valid;
      if (bus1.out_valid && bus1.out_ready && !kill) begin
        if (sb1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result1: actual quot=%h required no result", bus1.out_quot);
        end else begin
          exp_t e;
          e = sb1.pop_front();
          chk("quot1", bus1.out_quot, e.q);
          chk("rem1", bus1.out_rem, e.r);
          chk("dbz1", {31'b0, bus1.out_dbz}, {31'b0, e.dbz});
          chk("lat1", first1 - e.acc, e.lat);
        end
      end
    end
  end

  // Monitor for the STEP=4 instance.
  logic v4_prev = 1'b0;
  int   first4  = 0;
  always @(negedge clk) begin
    if (!rst) begin
      v4_prev = 1'b0;
    end else begin
      if (bus4.out_valid && !v4_prev) first4 = cyc;
      v4_prev = bus4.out_valid;
      if (bus4.out_valid && bus4.out_ready && !kill4) begin
        if (sb4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result4: actual quot=%h required no result", bus4.out_quot);
        end else begin
          exp_t e;
          e = sb4.pop_front();
          chk("quot4", bus4.out_quot, e.q);
          chk("rem4", bus4.out_rem, e.r);
          chk("dbz4", {31'b0, bus4.out_dbz}, {31'b0, e.dbz});
          chk("lat4", first4 - e.acc, e.lat);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input bit d4, input bit push, input logic sgn,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input int lat);
    int   n;
    exp_t e;
    n = 0;
    if (d4) begin
      bus4.in_valid = 1'b1; bus4.in_signed = sgn; bus4.in_dividend = x; bus4.in_divisor = y;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_signed = sgn; bus1.in_dividend = x; bus1.in_divisor = y;
    end
    @(negedge clk);
    while (!(d4 ? bus4.in_ready : bus1.in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: actual in_ready=0 required in_ready=1");
    end else if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.acc = cyc; e.lat = lat;
      if (d4) sb4.push_back(e);
      else    sb1.push_back(e);
    end
    if (d4) bus4.in_valid = 1'b0;
    else    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit d4);
    int n;
    n = 0;
    while ((d4 ? sb4.size() : sb1.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: actual pending=%0d required pending=0",
               d4 ? sb4.size() : sb1.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus1.in_valid = 1'b0; bus1.in_signed = 1'b0; bus1.in_dividend = '0; bus1.in_divisor = '0;
    bus1.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_signed = 1'b0; bus4.in_dividend = '0; bus4.in_divisor = '0;
    bus4.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_quot", bus1.out_quot, 32'd0);
    chk("rst_rem", bus1.out_rem, 32'd0);
    chk("rst_dbz", {31'b0, bus1.out_dbz}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, bus1.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Unsigned basics, both STEP widths
    issue(0, 1, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 32);
    wait_done(0);
    issue(1, 1, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 8);
    wait_done(1);

    // Signed: remainder takes the dividend's sign
    issue(0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 32);
    wait_done(0);
    issue(0, 1, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 32);
    wait_done(0);
    issue(0, 1, 0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 0, 32);
    wait_done(0);
    issue(1, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 8);
    wait_done(1);

    // Divide by zero: result visible right after the accept edge
    issue(0, 1, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
    wait_done(0);
    issue(0, 1, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
    wait_done(0);
    issue(0, 1, 1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 0);
    wait_done(0);
    issue(1, 1, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
    wait_done(1);

    // Signed overflow wraps; unsigned large divisor
    issue(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 32);
    wait_done(0);
    issue(0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 32);
    wait_done(0);

    // Backpressure: result held for 10 cycles, then one-cycle out_ready pulse
    bus1.out_ready = 1'b0;
    issue(0, 1, 0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 32);
    n = 0;
    @(negedge clk);
    while (!bus1.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", {31'b0, bus1.out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_quot", bus1.out_quot, 32'd333);
      chk("bp_hold_rem", bus1.out_rem, 32'd1);
      chk("bp_in_ready", {31'b0, bus1.in_ready}, 32'd0);
      chk("bp_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("bp_after_in_ready", {31'b0, bus1.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus1.out_ready = 1'b1;
    issue(0, 1, 1, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 32'hFFFF_FFFA, 0, 32);
    wait_done(0);

    // Flush 10 cycles into CALC
    issue(0, 0, 0, 32'd12345, 32'd6, 32'd0, 32'd0, 0, 32);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_in_ready", {31'b0, bus1.in_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus1.out_valid) n++;
      @(negedge clk);
    end
    chk("kill_no_valid", n, 32'd0);
    @(posedge clk); #1;
    issue(0, 1, 0, 32'd1000, 32'd10, 32'd100, 32'd0, 0, 32);
    wait_done(0);

    // kill together with in_valid: no accept
    kill = 1'b1;
    bus1.in_valid = 1'b1; bus1.in_signed = 1'b0; bus1.in_dividend = 32'd50; bus1.in_divisor = 32'd5;
    @(negedge clk);
    chk("kill_req_in_ready", {31'b0, bus1.in_ready}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("kill_req_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // kill in DONE overrides out_ready and discards the result
    bus1.out_ready = 1'b0;
    issue(0, 0, 0, 32'd9, 32'd0, 32'd0, 32'd0, 1, 0);
    @(negedge clk);
    chk("done_dbz_valid", {31'b0, bus1.out_valid}, 32'd1);
    @(posedge clk); #1;
    kill = 1'b1;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("done_kill_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("done_kill_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // Async reset mid-CALC, between edges
    issue(0, 0, 0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 32);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("arst_quot", bus1.out_quot, 32'd0);
    chk("arst_rem", bus1.out_rem, 32'd0);
    chk("arst_dbz", {31'b0, bus1.out_dbz}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {31'b0, bus1.in_ready}, 32'd1);
    @(posedge clk); #1;
    issue(0, 1, 0, 32'd99, 32'd9, 32'd11, 32'd0, 0, 32);
    wait_done(0);

    repeat (3) @(posedge clk);
    chk("pending1", sb1.size(), 32'd0);
    chk("pending4", sb4.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
